mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single byte-wide RAM port between the instruction-fetch requester (IF) and the load/store requester (MEM).
- Sequences multi-byte reads and writes as back-to-back byte accesses, then hands assembled words back to the requester.
- Sits between the pipeline stages and the external RAM interface. Its busy output feeds the stall controller.

Parameters:
- ADDR_W, 18, width of RAM byte address; internal address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- if_req_i  in  1  IF word-read request; may be withdrawn at any time (flush)
- if_addr_i  in  ADDR_W  IF byte address
- if_data_o  out  32  fetched word, little-endian
- if_done_o  out  1  one-cycle pulse, if_data_o valid
- mem_req_i  in  1  MEM request; held until mem_done_o
- mem_we_i  in  1  1=write, 0=read
- mem_size_i  in  2  00=1B, 01=2B, 10/11=4B
- mem_addr_i  in  ADDR_W  MEM byte address, unaligned allowed
- mem_wdata_i  in  32  write data, byte k = bits[8k+7:8k]
- mem_rdata_o  out  32  read data, zero above size
- mem_done_o  out  1  one-cycle pulse, access complete
- ram_addr_o  out  ADDR_W  RAM byte address
- ram_dout_o  out  8  RAM write byte
- ram_wr_o  out  1  RAM write enable
- ram_din_i  in  8  RAM read byte, valid the cycle after ram_addr_o is presented
- busy_o  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0 immediately, including ram_wr_o.
  - State goes to IDLE; counter and captured data are cleared.
- All outputs are registered.
- States: IDLE, RD, WR, GAP. Internal registers: owner (IF/MEM), byte count n in {1,2,4}, counter k, base address.
- IDLE grant, evaluated at the clock edge:
  - mem_req_i beats if_req_i.
  - MEM grant: n taken from mem_size_i; go to WR if mem_we_i, else RD.
  - IF grant: n=4, go to RD.
  - On grant: ram_addr_o=base, k=0. For WR, also ram_dout_o=byte0 and ram_wr_o=1.
  - No request: stay in IDLE.
- RD, at each edge:
  - Capture ram_din_i into byte k of the data register.
  - If k<n-1: ram_addr_o=base+k+1 and k=k+1.
  - If k=n-1: load if_data_o/mem_rdata_o with the assembled word, pulse the owner's done, go to GAP.
  - n-byte read: done high in the cycle after the n-th edge following grant. 4B read gives done 4 cycles after the grant edge.
- WR, at each edge:
  - If k<n-1: drive byte k+1 and base+k+1, hold ram_wr_o=1.
  - Otherwise: ram_wr_o=0, pulse mem_done_o, go to GAP.
  - ram_wr_o is high for exactly n cycles.
- GAP:
  - One dead cycle; requests are ignored, so a requester that drops req on seeing done is not re-granted.
  - Then go to IDLE.
- IF abort:
  - In RD with owner=IF, if if_req_i=0 at an edge, go to IDLE without a done pulse.
  - if_data_o keeps its previous value.
  - A MEM request pending at that time is granted on the following IDLE edge.
- MEM is never aborted. A mem_req_i drop mid-access is ignored and the access completes.
- Address wrap: base+k is truncated to ADDR_W bits; 0x3FFFF+1 → 0x00000.
- Read data: bytes at index ≥n are 0 in mem_rdata_o. No sign extension; that is done in the MEM stage.
- Done outputs: pulse exactly one cycle. Data outputs hold until the next completion for the same requester.
- Simultaneous requests in IDLE: MEM is served first, IF waits. IF is guaranteed service because MEM issues at most one access per instruction.
- Reset mid-write: ram_wr_o drops asynchronously; a partial write is acceptable.

Decomposition:
- Shared package holds:
  - size encodings (SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10)
  - state encodings (IDLE, RD, WR, GAP)
  - owner encodings
  - default ADDR_W
- Single module; no sub-module. Byte steering is a small indexed mux/demux inside the datapath.

Test Plan:
- IF read at 0x00010, RAM holds 13,00,00,93 at 0x10..0x13 → ram_addr_o steps 0x10..0x13 on consecutive cycles; if_done_o pulses 4 cycles after grant; if_data_o=0x93000013.
- MEM byte write, addr 0x00104, wdata 0xDEADBEEF, size 00 → one cycle ram_wr_o=1, ram_addr_o=0x104, ram_dout_o=0xEF; mem_done_o next cycle.
- if_req_i and mem_req_i rise together, MEM half read at 0x3FFFF → MEM is served first: addresses 0x3FFFF then 0x00000, mem_rdata_o=0x0000XXYY. Then GAP, then the IF read starts.
- IF read granted, if_req_i dropped after 2 bytes → no if_done_o; state returns to IDLE; a new IF request at a new address fetches the correct word.
- MEM word write while if_req_i is held → ram_wr_o high for exactly 4 cycles with bytes EF,BE,AD,DE. IF is granted only after GAP; mem_done_o pulses once.
- rst_n asserted low during the 3rd write byte → ram_wr_o, busy_o and done outputs go 0 without a clock edge; after release, an IF read completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the byte-wide RAM port arbiter: access sizes, FSM states,
// requester ownership and the default address width.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 18;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    GAP
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_e;

  // 2'b11 is treated as a word access, same as SZ_W.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and load/store,
// sequencing multi-byte accesses as back-to-back byte cycles with registered outputs.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i,
  output logic              busy_o
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [2:0]        n_q, n_d;
  logic [1:0]        k_q, k_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic              busy_q;

  logic [1:0]        k_inc;
  logic [ADDR_W-1:0] addr_inc;
  logic              last;
  logic [31:0]       rd_word;

  assign k_inc    = k_q + 2'd1;
  assign addr_inc = base_q + ADDR_W'(k_inc);
  assign last     = ({1'b0, k_q} == (n_q - 3'd1));

  // data_q holds the write word during WR and the partially assembled word during RD;
  // it is cleared on read grant so bytes above the access size read back as zero.
  always_comb begin
    rd_word                       = data_q;
    rd_word[{k_q, 3'b000} +: 8]   = ram_din_i;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    n_d         = n_q;
    k_d         = k_q;
    base_d      = base_q;
    data_d      = data_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          owner_d    = OWN_MEM;
          n_d        = size_bytes(mem_size_i);
          k_d        = '0;
          base_d     = mem_addr_i;
          ram_addr_d = mem_addr_i;
          if (mem_we_i) begin
            state_d    = WR;
            data_d     = mem_wdata_i;
            ram_dout_d = mem_wdata_i[7:0];
            ram_wr_d   = 1'b1;
          end else begin
            state_d = RD;
            data_d  = '0;
          end
        end else if (if_req_i) begin
          owner_d    = OWN_IF;
          n_d        = 3'd4;
          k_d        = '0;
          base_d     = if_addr_i;
          ram_addr_d = if_addr_i;
          data_d     = '0;
          state_d    = RD;
        end
      end
      RD: begin
        if (owner_q == OWN_IF && !if_req_i) begin
          state_d = IDLE;
        end else begin
          data_d = rd_word;
          if (!last) begin
            k_d        = k_inc;
            ram_addr_d = addr_inc;
          end else begin
            state_d = GAP;
            if (owner_q == OWN_IF) begin
              if_data_d = rd_word;
              if_done_d = 1'b1;
            end else begin
              mem_rdata_d = rd_word;
              mem_done_d  = 1'b1;
            end
          end
        end
      end
      WR: begin
        if (!last) begin
          k_d        = k_inc;
          ram_addr_d = addr_inc;
          ram_dout_d = data_q[{k_inc, 3'b000} +: 8];
          ram_wr_d   = 1'b1;
        end else begin
          state_d    = GAP;
          mem_done_d = 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      n_q         <= '0;
      k_q         <= '0;
      base_q      <= '0;
      data_q      <= '0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      n_q         <= n_d;
      k_q         <= k_d;
      base_q      <= base_d;
      data_q      <= data_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign if_data_o   = if_data_q;
  assign if_done_o   = if_done_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_done_o  = mem_done_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_dout_o  = ram_dout_q;
  assign ram_wr_o    = ram_wr_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random transactions checked
// against a transaction-level memory model with per-cycle timing expectations.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 18;
  localparam logic [AW-1:0] AMASK = '1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [31:0]   if_data;
  logic          if_done;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [1:0]    mem_size = '0;
  logic [AW-1:0] mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [31:0]   mem_rdata;
  logic          mem_done;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dout;
  logic          ram_wr;
  logic [7:0]    ram_din;
  logic          busy;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_if = '0;
  logic [31:0] last_mem = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_data_o   (if_data),
    .if_done_o   (if_done),
    .mem_req_i   (mem_req),
    .mem_we_i    (mem_we),
    .mem_size_i  (mem_size),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_rdata_o (mem_rdata),
    .mem_done_o  (mem_done),
    .ram_addr_o  (ram_addr),
    .ram_dout_o  (ram_dout),
    .ram_wr_o    (ram_wr),
    .ram_din_i   (ram_din),
    .busy_o      (busy)
  );

  // Power-up RAM contents as a pure function of address.
  function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
    case (a)
      18'h00010: return 8'h13;
      18'h00011: return 8'h00;
      18'h00012: return 8'h00;
      18'h00013: return 8'h93;
      default:   return a[7:0] ^ {a[15:10], a[17:16]} ^ 8'h5A;
    endcase
  endfunction

  // RAM model: address registered in the DUT, read data combinational from it.
  logic [7:0] ram     [0:(1<<AW)-1];
  bit         written [0:(1<<AW)-1];
  assign ram_din = written[ram_addr] ? ram[ram_addr] : init_byte(ram_addr);
  always @(posedge clk) begin
    if (ram_wr) begin
      ram[ram_addr]     <= ram_dout;
      written[ram_addr] <= 1'b1;
    end
  end

  // Reference memory: bytes the bench expects to have been written.
  logic [7:0] refm [logic [AW-1:0]];

  function automatic logic [7:0] ref_byte(input logic [AW-1:0] a);
    if (refm.exists(a)) return refm[a];
    return init_byte(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [AW-1:0] addr, input int unsigned n);
    logic [31:0] w;
    logic [AW-1:0] a;
    w = '0;
    for (int unsigned i = 0; i < n; i++) begin
      a = addr + AW'(i);
      w[8*i +: 8] = ref_byte(a);
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int unsigned c;
    c = 0;
    do begin
      tick();
      c++;
    end while (!busy && c < 20);
    check({tag, " grant"}, 32'(busy), 32'd1);
  endtask

  task automatic mem_access(input logic we, input logic [1:0] sz,
                            input logic [AW-1:0] addr, input logic [31:0] wd);
    int unsigned n;
    logic [31:0] exp;
    logic [AW-1:0] a;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    check("mem_rdata hold", mem_rdata, last_mem);
    check("if_data hold", if_data, last_if);
    mem_we = we; mem_size = sz; mem_addr = addr; mem_wdata = wd; mem_req = 1'b1;
    wait_grant("mem");
    check("mem addr0", 32'(ram_addr), 32'(addr));
    check("mem wr0", 32'(ram_wr), 32'(we));
    if (we) check("mem dout0", 32'(ram_dout), 32'(wd[7:0]));
    for (int unsigned c = 1; c <= n; c++) begin
      tick();
      if (c < n) begin
        a = addr + AW'(c);
        check("mem addr", 32'(ram_addr), 32'(a));
        check("mem wr", 32'(ram_wr), 32'(we));
        if (we) check("mem dout", 32'(ram_dout), 32'(wd[8*c +: 8]));
        check("mem done early", 32'(mem_done), 32'd0);
      end
    end
    check("mem done", 32'(mem_done), 32'd1);
    check("mem wr end", 32'(ram_wr), 32'd0);
    check("mem busy gap", 32'(busy), 32'd1);
    check("if done idle", 32'(if_done), 32'd0);
    if (we) begin
      for (int unsigned i = 0; i < n; i++) begin
        a = addr + AW'(i);
        refm[a] = wd[8*i +: 8];
      end
    end else begin
      exp = ref_read(addr, n);
      check("mem rdata", mem_rdata, exp);
      last_mem = exp;
    end
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
    check("mem done pulse", 32'(mem_done), 32'd0);
    check("mem busy end", 32'(busy), 32'd0);
    if (we) begin
      for (int unsigned i = 0; i < n; i++) begin
        a = addr + AW'(i);
        check("ram byte", 32'(ram[a]), 32'(wd[8*i +: 8]));
      end
    end
  endtask

  task automatic if_read(input logic [AW-1:0] addr);
    logic [31:0] exp;
    logic [AW-1:0] a;
    check("if_data hold", if_data, last_if);
    check("mem_rdata hold", mem_rdata, last_mem);
    if_addr = addr; if_req = 1'b1;
    wait_grant("if");
    check("if addr0", 32'(ram_addr), 32'(addr));
    check("if wr", 32'(ram_wr), 32'd0);
    for (int unsigned c = 1; c <= 4; c++) begin
      tick();
      if (c < 4) begin
        a = addr + AW'(c);
        check("if addr", 32'(ram_addr), 32'(a));
        check("if done early", 32'(if_done), 32'd0);
      end
    end
    exp = ref_read(addr, 4);
    check("if done", 32'(if_done), 32'd1);
    check("if data", if_data, exp);
    check("mem done idle", 32'(mem_done), 32'd0);
    last_if = exp;
    if_req = 1'b0;
    tick();
    check("if done pulse", 32'(if_done), 32'd0);
    check("if busy end", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [31:0]   rw;
    logic [1:0]    rs;
    int unsigned   kind;

    // Asynchronous reset: outputs clear with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst ram_wr", 32'(ram_wr), 32'd0);
    check("rst ram_addr", 32'(ram_addr), 32'd0);
    check("rst if_data", if_data, 32'd0);
    check("rst mem_rdata", mem_rdata, 32'd0);
    check("rst dones", {30'd0, if_done, mem_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // IF fetch of a known word.
    if_read(18'h00010);
    check("tp if word", if_data, 32'h93000013);

    // MEM byte write.
    mem_access(1'b1, 2'b00, 18'h00104, 32'hDEADBEEF);

    // Simultaneous requests: MEM half read across the address wrap, then IF.
    if_addr = 18'h00400; if_req = 1'b1;
    mem_access(1'b0, 2'b01, 18'h3FFFF, 32'h0);
    check("tp wrap half", mem_rdata, {16'h0, init_byte(18'h00000), init_byte(18'h3FFFF)});
    if_read(18'h00400);

    // IF abort after two captured bytes.
    if_addr = 18'h00800; if_req = 1'b1;
    wait_grant("abort");
    tick(); tick();
    if_req = 1'b0;
    tick();
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(if_done), 32'd0);
    check("abort data", if_data, last_if);
    tick();
    check("abort no done", 32'(if_done), 32'd0);
    if_read(18'h00900);

    // MEM word write with IF held; IF follows after GAP and reads it back.
    if_addr = 18'h00200; if_req = 1'b1;
    mem_access(1'b1, 2'b10, 18'h00200, 32'hDEADBEEF);
    if_read(18'h00200);
    check("tp word readback", if_data, 32'hDEADBEEF);

    // Reset in the middle of the third write byte.
    mem_we = 1'b1; mem_size = 2'b10; mem_addr = 18'h00300; mem_wdata = 32'h11223344; mem_req = 1'b1;
    wait_grant("rstwr");
    tick(); tick();
    check("rstwr byte2", 32'(ram_dout), 32'h22);
    check("rstwr wr", 32'(ram_wr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstwr ram_wr", 32'(ram_wr), 32'd0);
    check("rstwr busy", 32'(busy), 32'd0);
    check("rstwr dones", {30'd0, if_done, mem_done}, 32'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    refm[18'h00300] = 8'h44;
    refm[18'h00301] = 8'h33;
    last_if = '0; last_mem = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    if_read(18'h00300);

    // Random sequential transactions.
    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 2);
      ra = AW'($urandom);
      if ($urandom_range(0, 3) == 0) ra = AMASK - AW'($urandom_range(0, 3));
      rw = $urandom;
      rs = 2'($urandom_range(0, 3));
      case (kind)
        0: if_read(ra);
        1: mem_access(1'b0, rs, ra, 32'h0);
        default: begin
          mem_access(1'b1, rs, ra, rw);
          mem_access(1'b0, 2'b10, ra, 32'h0);
          if_read(ra);
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
